lsu_stage: RTL
==============

Name: lsu_stage

Overview:
- Load/store unit directly downstream of the execute stage.
- Latches one memory request per transaction from execute: address, store data, mem_op and destination register.
- Runs a valid/ready request plus response handshake on the data-memory bus.
- For loads, issues a single-cycle register-file write-back. One transaction in flight; lsu_ready is low while busy.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed 32; byte lanes assume 4)
- TIMEOUT_CYCLES, 255, bus wait limit used only when LSU_BUS_TIMEOUT_EN is defined

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- lsu_valid  in  1  request from execute; may be a 1-cycle pulse
- lsu_ready  out  1  high only in IDLE; execute issues only when high
- lsu_addr  in  32  byte address
- lsu_wdata  in  32  store data
- lsu_mem_op  in  2  0=none, 1=LW, 2=SW, 3=LBU
- lsu_rd_addr  in  5  load destination
- mem_req_valid  out  1  bus request
- mem_req_ready  in  1  bus accepts request
- mem_req_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_req_wen  out  1  1=store
- mem_req_wdata  out  32  store data
- mem_req_wstrb  out  4  byte enables (4'hF for SW, 0 for loads)
- mem_resp_valid  in  1  response/ack
- mem_resp_rdata  in  32  read data
- mem_resp_ready  out  1  high only in WAIT
- wb_write  out  1  1-cycle register-file write strobe
- wb_rd_addr  out  5  write-back register
- wb_rd_data  out  32  write-back data
- lsu_err  out  1  1-cycle pulse: misaligned LW/SW (or bus timeout)

Behaviour:
- Reset: all outputs 0 except lsu_ready=1. State=IDLE. Internal latches cleared. Reset mid-transaction aborts it; no write-back and no error pulse.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: lsu_ready=1. Accept when lsu_valid=1 and mem_op!=0.
  - On accept, latch addr, wdata, op and rd into internal registers, then check alignment.
  - LW/SW with addr[1:0]!=0: no bus access; lsu_err=1 for the next cycle; state goes to DONE with no write-back.
  - Otherwise go to REQ.
  - lsu_valid with mem_op=0 is ignored; lsu_ready stays 1.
- REQ:
  - mem_req_valid=1; addr, wen, wdata and wstrb are held stable until mem_req_ready=1.
  - Handshake completes in the cycle where valid&ready are both 1; next state is WAIT.
  - Request fields must not change while valid=1 and ready=0.
- WAIT: mem_resp_ready=1. On mem_resp_valid:
  - LW: wb_rd_data=rdata.
  - LBU: wb_rd_data={24'b0, byte addr[1:0] of rdata}, where byte 0 = bits 7:0 (little-endian).
  - Loads: wb_write=1 and wb_rd_addr=latched rd in the following cycle, one cycle wide. rd=0 still pulses; the regfile discards it.
  - SW: no write-back.
  - Next state is DONE.
  - A response arriving in the same cycle as the request handshake is not sampled; it is sampled from WAIT onward only.
- DONE: one cycle; lsu_ready=0, outputs registered, then IDLE. Back-to-back throughput is 1 transaction per 4 cycles minimum. Minimum latency from accept to wb_write is 3 cycles with a zero-wait bus.
- wb_write and lsu_err are never high in the same cycle.
- Outputs are registered; no combinational path from inputs to outputs other than none.

Optional Feature:
- Macro: LSU_BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter is cleared on entering REQ and increments each cycle in REQ or WAIT without handshake progress.
  - On reaching TIMEOUT_CYCLES: drop mem_req_valid and mem_resp_ready, pulse lsu_err for 1 cycle, no write-back, go to DONE.
  - Counter resets on each state change.
- Undefined: no counter; the unit waits indefinitely in REQ/WAIT.

Test Plan:
- LW addr=0x80000004, bus ready immediately, rdata=0xDEADBEEF, rd=5 -> mem_req_addr=0x80000004, wstrb=0; wb_write pulses once with rd=5, data 0xDEADBEEF, 3 cycles after accept.
- SW addr=0x80000010, wdata=0x12345678, mem_req_ready held low 4 cycles -> request fields stable throughout with wen=1, wstrb=F; no wb_write; lsu_ready returns high after DONE.
- LBU addr=0x80000003, rdata=0xAABBCCDD -> wb_rd_data=0x000000AA, mem_req_addr=0x80000000.
- LW addr=0x80000002 -> no mem_req_valid; lsu_err pulses 1 cycle; no wb_write.
- rst_n asserted low while in WAIT -> all outputs go to reset values immediately (async), lsu_ready=1. A late mem_resp_valid after reset release causes no write-back.
- With LSU_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_req_ready held 0 -> lsu_err pulses after 8 cycles in REQ; unit returns to IDLE. Without the macro, the unit stays in REQ.

Source files
------------

// File: rtl/lsu_stage_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave):
// a valid/ready request channel plus a valid/ready response channel.
interface lsu_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_wen;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [3:0]        mem_req_wstrb;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;
    logic              mem_resp_ready;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        output mem_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        input  mem_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );
endinterface

// File: rtl/lsu_stage.sv
// Single-outstanding load/store unit: IDLE -> REQ -> WAIT -> DONE, all outputs registered.
// Optional bus watchdog enabled by defining LSU_BUS_TIMEOUT_EN.
module lsu_stage #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [1:0]        lsu_mem_op,
    input  logic [4:0]        lsu_rd_addr,
    lsu_mem_if.master         mem,
    output logic              wb_write,
    output logic [4:0]        wb_rd_addr,
    output logic [DATA_W-1:0] wb_rd_data,
    output logic              lsu_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {OP_NONE = 2'd0, OP_LW = 2'd1, OP_SW = 2'd2, OP_LBU = 2'd3} mem_op_t;

    if (DATA_W != 32 || ADDR_W < 3 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("lsu_stage: DATA_W must be 32, ADDR_W >= 3, TIMEOUT_CYCLES >= 1");
    end

    state_t            state;
    mem_op_t           op_q;
    logic [4:0]        rd_q;
    logic [1:0]        addr_lo_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic              req_wen_q;
    logic [3:0]        req_wstrb_q;
    logic              req_valid_q;
    logic              resp_ready_q;

    mem_op_t in_op;
    logic    in_misaligned;

    assign in_op         = mem_op_t'(lsu_mem_op);
    assign in_misaligned = (in_op == OP_LW || in_op == OP_SW) && (lsu_addr[1:0] != 2'b00);

    assign mem.mem_req_valid  = req_valid_q;
    assign mem.mem_req_addr   = req_addr_q;
    assign mem.mem_req_wen    = req_wen_q;
    assign mem.mem_req_wdata  = req_wdata_q;
    assign mem.mem_req_wstrb  = req_wstrb_q;
    assign mem.mem_resp_ready = resp_ready_q;

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;
    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // NOTE: every register here uses non-blocking (<=) so all state updates
    // see pre-edge values; blocking assignments would create order-dependent logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            op_q         <= OP_NONE;
            rd_q         <= '0;
            addr_lo_q    <= '0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_wen_q    <= 1'b0;
            req_wstrb_q  <= '0;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            lsu_ready    <= 1'b1;
            wb_write     <= 1'b0;
            wb_rd_addr   <= '0;
            wb_rd_data   <= '0;
            lsu_err      <= 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            wb_write <= 1'b0;
            lsu_err  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (lsu_valid && in_op != OP_NONE) begin
                        op_q        <= in_op;
                        rd_q        <= lsu_rd_addr;
                        addr_lo_q   <= lsu_addr[1:0];
                        req_addr_q  <= {lsu_addr[ADDR_W-1:2], 2'b00};
                        req_wdata_q <= lsu_wdata;
                        req_wen_q   <= (in_op == OP_SW);
                        req_wstrb_q <= (in_op == OP_SW) ? 4'hF : 4'h0;
                        lsu_ready   <= 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
                        tmo_cnt     <= '0;
`endif
                        if (in_misaligned) begin
                            lsu_err <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            req_valid_q <= 1'b1;
                            state       <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem.mem_req_ready) begin
                        req_valid_q  <= 1'b0;
                        resp_ready_q <= 1'b1;
                        state        <= S_WAIT;
`ifdef LSU_BUS_TIMEOUT_EN
                        tmo_cnt      <= '0;
                    end else if (tmo_hit) begin
                        req_valid_q <= 1'b0;
                        lsu_err     <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
`endif
                    end
                end
                S_WAIT: begin
                    if (mem.mem_resp_valid) begin
                        resp_ready_q <= 1'b0;
                        state        <= S_DONE;
                        if (op_q != OP_SW) begin
                            wb_write   <= 1'b1;
                            wb_rd_addr <= rd_q;
                            // LBU picks the little-endian byte lane named by the low address bits.
                            wb_rd_data <= (op_q == OP_LBU)
                                ? {{(DATA_W-8){1'b0}}, mem.mem_resp_rdata[{addr_lo_q, 3'b000} +: 8]}
                                : mem.mem_resp_rdata;
                        end
`ifdef LSU_BUS_TIMEOUT_EN
                        tmo_cnt <= '0;
                    end else if (tmo_hit) begin
                        resp_ready_q <= 1'b0;
                        lsu_err      <= 1'b1;
                        tmo_cnt      <= '0;
                        state        <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
`endif
                    end
                end
                S_DONE: begin
                    lsu_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
